fmq_cmd_master: RTL and testbench

Initiator side of the levitator board's 3-byte UART command protocol. It accepts one command request at a time (offset write, divisor load, DAC level, reload, or a query), encodes it into a command frame, and sends the frame byte by byte to a UART transmitter. It waits for each byte's echo before sending the next byte, and also collects the reply byte for queries. It sits on a master/controller FPGA between the sequencing logic and the UART link to one phased-array board.

---
 rtl/fmq_cmd_master.sv | 225 ++++++++++++++++++++++
 tb/tb_fmq_cmd_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmq_cmd_master.sv
// -----------------------------------------------------------------------------
// fmq_cmd_master
// Initiator side of the levitator board's 3-byte UART command protocol.
// Accepts one request at a time, encodes it into a 3-byte frame, sends each
// byte to the UART transmitter and waits for that byte's echo before it sends
// the next one. For query ops it also collects the single reply byte.
//
// Optional feature macro: FMQ_CMD_ECHO_CHECK_EN
//   defined   : every echo is compared with the byte sent; mismatches are
//               reported on rsp_err_echo (sticky across the frame).
//   undefined : any received byte counts as the echo; rsp_err_echo stays 0.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (req_ready high only in IDLE)
//   req_op/req_addr/req_data request opcode, channel and payload
//   rsp_valid                one-cycle completion pulse
//   rsp_data                 reply byte for queries, 0 otherwise
//   rsp_err_echo             echo mismatch seen in this frame
//   rsp_err_timeout          an echo or reply did not arrive in time
//   tx_data/tx_valid/tx_ready  byte stream to the UART transmitter
//   rx_data/rx_valid/rx_ready  byte stream from the UART receiver
//   busy                     state machine is not in IDLE
// -----------------------------------------------------------------------------
module fmq_cmd_master #(
  parameter int TIMEOUT     = 65535,
  parameter int TIMER_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [6:0]  req_addr,
  input  logic [18:0] req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err_echo,
  output logic        rsp_err_timeout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ECHO,
    S_WAIT_REPLY,
    S_DONE
  } state_t;

  // Index 0 is B0, the first byte on the wire.
  typedef logic [2:0][7:0] frame_t;

  state_t                 state;
  frame_t                 frame;
  frame_t                 req_frame;
  logic [1:0]             byte_idx;
  logic                   is_query;
  logic                   err_echo;
  logic                   echo_bad;
  logic                   timer_expired;
  logic [TIMER_WIDTH-1:0] timer;

  function automatic frame_t encode(input logic [2:0]  op,
                                    input logic [6:0]  addr,
                                    input logic [18:0] data);
    frame_t f;
    f = '0;
    case (op)
      3'd0: begin
        f[0] = {3'b100, addr[6:2]};
        f[1] = {1'b0, addr[1:0], data[11:7]};
        f[2] = {1'b0, data[6:0]};
      end
      3'd1: begin
        f[0] = {3'b101, data[18:14]};
        f[1] = {1'b0, data[13:7]};
        f[2] = {1'b0, data[6:0]};
      end
      3'd2: f[0] = 8'hC0;
      3'd3: begin
        f[0] = 8'hE0;
        f[1] = {6'b0, data[8:7]};
        f[2] = {1'b0, data[6:0]};
      end
      3'd4: f[0] = 8'hF0;
      3'd5: f[0] = 8'hE8;
      default: f = '0;
    endcase
    return f;
  endfunction

  assign req_frame     = encode(req_op, req_addr, req_data);
  assign timer_expired = (timer == TIMER_WIDTH'(TIMEOUT - 1));

`ifdef FMQ_CMD_ECHO_CHECK_EN
  assign echo_bad = (rx_data != frame[byte_idx]);
`else
  assign echo_bad = 1'b0;
`endif

  // NOTE: every register here is written with <= so that all state updates
  // see the pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      req_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_data        <= 8'h00;
      rsp_err_echo    <= 1'b0;
      rsp_err_timeout <= 1'b0;
      tx_data         <= 8'h00;
      tx_valid        <= 1'b0;
      rx_ready        <= 1'b0;
      busy            <= 1'b0;
      frame           <= '0;
      byte_idx        <= 2'd0;
      is_query        <= 1'b0;
      err_echo        <= 1'b0;
      timer           <= '0;
    end else begin
      // Bytes arriving outside the wait states are accepted and dropped.
      rx_ready <= 1'b1;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            err_echo  <= 1'b0;
            byte_idx  <= 2'd0;
            is_query  <= (req_op == 3'd2) || (req_op == 3'd5);
            if (req_op[2:1] == 2'b11) begin
              // Invalid op: no frame, complete on the next cycle.
              state           <= S_DONE;
              rsp_valid       <= 1'b1;
              rsp_data        <= 8'h00;
              rsp_err_echo    <= 1'b0;
              rsp_err_timeout <= 1'b0;
            end else begin
              state    <= S_SEND;
              frame    <= req_frame;
              tx_data  <= req_frame[0];
              tx_valid <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            timer    <= '0;
            state    <= S_WAIT_ECHO;
          end
        end

        S_WAIT_ECHO: begin
          if (rx_valid) begin
            // A bad echo does not stop the frame: the responder's 3-byte
            // shift buffer must still see all three bytes to stay aligned.
            err_echo <= err_echo | echo_bad;
            if (byte_idx != 2'd2) begin
              byte_idx <= byte_idx + 2'd1;
              tx_data  <= frame[byte_idx + 2'd1];
              tx_valid <= 1'b1;
              state    <= S_SEND;
            end else if (is_query) begin
              timer <= '0;
              state <= S_WAIT_REPLY;
            end else begin
              state           <= S_DONE;
              rsp_valid       <= 1'b1;
              rsp_data        <= 8'h00;
              rsp_err_echo    <= err_echo | echo_bad;
              rsp_err_timeout <= 1'b0;
            end
          end else if (timer_expired) begin
            state           <= S_DONE;
            rsp_valid       <= 1'b1;
            rsp_data        <= 8'h00;
            rsp_err_echo    <= err_echo;
            rsp_err_timeout <= 1'b1;
          end else begin
            timer <= timer + TIMER_WIDTH'(1);
          end
        end

        S_WAIT_REPLY: begin
          if (rx_valid) begin
            state           <= S_DONE;
            rsp_valid       <= 1'b1;
            rsp_data        <= rx_data;
            rsp_err_echo    <= err_echo;
            rsp_err_timeout <= 1'b0;
          end else if (timer_expired) begin
            state           <= S_DONE;
            rsp_valid       <= 1'b1;
            rsp_data        <= 8'h00;
            rsp_err_echo    <= err_echo;
            rsp_err_timeout <= 1'b1;
          end else begin
            timer <= timer + TIMER_WIDTH'(1);
          end
        end

        S_DONE: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmq_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_fmq_cmd_master
// Self-checking bench for fmq_cmd_master. A per-command model computes the
// frame bytes from the protocol rules with plain arithmetic, plays the
// responder (echo / corrupt / drop / reply, tx_ready stalls) and predicts on
// which cycle each output event must occur. Directed cases pin the model with
// literal byte values; a randomized run follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fmq_cmd_master;

  localparam int TO = 100;
`ifdef FMQ_CMD_ECHO_CHECK_EN
  localparam bit ECHO_CHK = 1'b1;
`else
  localparam bit ECHO_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [6:0]  req_addr = '0;
  logic [18:0] req_data = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err_echo;
  logic        rsp_err_timeout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sent_q[$];
  logic [7:0] last_rsp_data;
  logic       last_err_echo;
  logic       last_err_to;

  always #5 clk = ~clk;

  fmq_cmd_master #(.TIMEOUT(TO), .TIMER_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err_echo(rsp_err_echo), .rsp_err_timeout(rsp_err_timeout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame bytes from the protocol tables, written as arithmetic.
  function automatic void model_frame(input int op, input int addr, input int data,
                                      output logic [2:0][7:0] b, output int n, output bit q);
    b = '0; n = 3; q = 1'b0;
    case (op)
      0: begin b[0] = 8'(128 + addr / 4); b[1] = 8'((addr % 4) * 32 + (data / 128) % 32);
               b[2] = 8'(data % 128); end
      1: begin b[0] = 8'(160 + (data / 16384) % 32); b[1] = 8'((data / 128) % 128);
               b[2] = 8'(data % 128); end
      2: begin b[0] = 8'd192; q = 1'b1; end
      3: begin b[0] = 8'd224; b[1] = 8'((data / 128) % 4); b[2] = 8'(data % 128); end
      4: b[0] = 8'd240;
      5: begin b[0] = 8'd232; q = 1'b1; end
      default: n = 0;
    endcase
  endfunction

  // One full command. drop_idx 0..2 withholds that byte's echo, 3 withholds
  // a query's reply; -1 means the responder behaves.
  task automatic run_cmd(input int op, input int addr, input int data,
                         input int stall_idx, input int stall_len,
                         input int corrupt_idx, input logic [7:0] corrupt_xor,
                         input int drop_idx, input int dly, input logic [7:0] reply);
    logic [2:0][7:0] eb;
    int  n, cyc, exp_rsp, offer, echo_at, echo_idx, reply_at, stall_left, nsent_exp;
    bit  q, done, to_exp, err_exp;
    logic [7:0] data_exp;
    model_frame(op, addr, data, eb, n, q);
    sent_q.delete();
    to_exp    = (n > 0) && (drop_idx >= 0) && (drop_idx < 3 || q);
    nsent_exp = (n == 0) ? 0 : ((to_exp && drop_idx < 3) ? drop_idx + 1 : 3);
    err_exp   = ECHO_CHK && (n > 0) && (corrupt_idx >= 0) && (corrupt_idx < nsent_exp)
                && !(to_exp && corrupt_idx == drop_idx);
    data_exp  = (q && !to_exp) ? reply : 8'h00;

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    check("rx_ready_idle", rx_ready, 1);
    check("busy_idle", busy, 0);
    req_valid = 1'b1; req_op = 3'(op); req_addr = 7'(addr); req_data = 19'(data);

    cyc = 0; done = 1'b0; echo_at = -1; echo_idx = 0; reply_at = -1;
    exp_rsp    = (n == 0) ? 1 : -1;
    offer      = (n > 0) ? 0 : -1;
    stall_left = stall_len;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
      check("busy_frame", busy, 1);
      check("rsp_valid_timing", rsp_valid, cyc == exp_rsp);
      if (rsp_valid || cyc == exp_rsp) begin
        check("rsp_err_timeout", rsp_err_timeout, to_exp);
        check("rsp_err_echo", rsp_err_echo, err_exp);
        check("rsp_data", rsp_data, data_exp);
        last_rsp_data = rsp_data; last_err_echo = rsp_err_echo; last_err_to = rsp_err_timeout;
        done = 1'b1;
      end else begin
        check("tx_valid", tx_valid, offer >= 0);
        if (offer >= 0) begin
          check("tx_data", tx_data, eb[offer]);
          if (offer == stall_idx && stall_left > 0) begin
            stall_left--;
          end else begin
            tx_ready = 1'b1;
            sent_q.push_back(tx_data);
            if (offer == drop_idx) exp_rsp = cyc + 1 + TO;
            else begin echo_at = cyc + 1 + dly; echo_idx = offer; end
            offer = -1;
          end
        end
        if (cyc == echo_at) begin
          rx_valid = 1'b1;
          rx_data  = eb[echo_idx] ^ ((echo_idx == corrupt_idx) ? corrupt_xor : 8'h00);
          echo_at  = -1;
          if (echo_idx < 2) offer = echo_idx + 1;
          else if (q) begin
            if (drop_idx == 3) exp_rsp = cyc + 1 + TO;
            else reply_at = cyc + 1 + dly;
          end else exp_rsp = cyc + 1;
        end else if (cyc == reply_at) begin
          rx_valid = 1'b1; rx_data = reply; exp_rsp = cyc + 1;
        end
      end
    end
    if (!done) check("rsp_within_budget", 0, 1);
    rx_valid = 1'b0; tx_ready = 1'b0;
    check("sent_count", sent_q.size(), nsent_exp);
    @(negedge clk);
    check("req_ready_after_done", req_ready, 1);
    check("rsp_valid_one_cycle", rsp_valid, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_sent3(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
    logic [7:0] a [3];
    for (int i = 0; i < 3; i++) a[i] = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
    check({name, "_b0"}, a[0], b0);
    check({name, "_b1"}, a[1], b1);
    check({name, "_b2"}, a[2], b2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // Reset state while rst is held low.
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_err_echo", rsp_err_echo, 0);
    check("rst_err_timeout", rsp_err_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_ready", rx_ready, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);

    // Offset write, clean loopback.
    run_cmd(0, 'h55, 'hABC, -1, 0, -1, 8'h00, -1, 1, 8'h00);
    check_sent3("op0", 8'h95, 8'h35, 8'h3C);
    check("op0_rsp_data", last_rsp_data, 8'h00);

    // Version query with reply 0x07.
    run_cmd(5, 0, 0, -1, 0, -1, 8'h00, -1, 0, 8'h07);
    check_sent3("op5", 8'hE8, 8'h00, 8'h00);
    check("op5_reply", last_rsp_data, 8'h07);

    // Divisor load with tx_ready held low for 5 cycles on B1.
    run_cmd(1, 0, 100, 1, 5, -1, 8'h00, -1, 2, 8'h00);
    check_sent3("op1", 8'hA0, 8'h00, 8'h64);

    // B1 echo corrupted 0x35 -> 0x36.
    run_cmd(0, 'h55, 'hABC, -1, 0, 1, 8'h03, -1, 0, 8'h00);
    check_sent3("corrupt", 8'h95, 8'h35, 8'h3C);
    check("corrupt_err_echo", last_err_echo, ECHO_CHK);

    // No echo for B0: only one byte, timeout flagged.
    run_cmd(3, 0, 'h1FF, -1, 0, -1, 8'h00, 0, 0, 8'h00);
    check("timeout_one_byte", sent_q.size(), 1);
    check("timeout_flag", last_err_to, 1);

    // Invalid op.
    run_cmd(7, 0, 0, -1, 0, -1, 8'h00, -1, 0, 8'h00);

    // Reset while waiting for B1's echo.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_addr = 7'h12; req_data = 19'h345;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      rx_valid = 1'b0; tx_ready = 1'b0;
      if (tx_valid) begin
        tx_ready = 1'b1; cnt++; rx_data = tx_data;
        @(negedge clk);
        tx_ready = 1'b0;
        if (cnt < 2) rx_valid = 1'b1;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0; tx_ready = 1'b0;
    check("midframe_two_bytes", cnt, 2);
    check("midframe_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("midframe_rst_tx_valid", tx_valid, 0);
    check("midframe_rst_busy", busy, 0);
    check("midframe_rst_rx_ready", rx_ready, 0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midframe_no_rsp", rsp_valid, 0);
    end
    run_cmd(4, 0, 0, -1, 0, -1, 8'h00, -1, 1, 8'h00);
    check_sent3("op4", 8'hF0, 8'h00, 8'h00);

    // Randomized commands and responder behaviour.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        // Stray byte in IDLE must be ignored.
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'($urandom);
        @(negedge clk); rx_valid = 1'b0;
      end
      run_cmd($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, (1 << 19) - 1),
              $urandom_range(0, 3), $urandom_range(0, 4),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1, 8'($urandom_range(1, 255)),
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1,
              $urandom_range(0, 3), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
